// File: rtl/accum_div.sv
// accum_div: sequential radix-2 restoring divider, one quotient bit per cycle.
// Unsigned BITS_A-bit dividend by unsigned BITS_B-bit divisor, valid/ready on
// both sides. Divide by zero yields an all-ones quotient and the low dividend
// bits as remainder, which falls out of the algorithm without special casing.
// Optional macro ACCUM_DIV_EARLY_EXIT_EN: start iterating at the dividend's
// leading one, so latency becomes msb(A)+1 cycles instead of BITS_A.
module accum_div #(
    parameter int BITS_A = 256,
    parameter int BITS_B = BITS_A
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BITS_A-1:0] i_dat_a,
    input  logic [BITS_B-1:0] i_dat_b,
    input  logic              i_val,
    output logic              o_rdy,
    output logic [BITS_A-1:0] o_quo,
    output logic [BITS_B-1:0] o_rem,
    output logic              o_val,
    input  logic              i_rdy
);

    localparam int IW = (BITS_A > 1) ? $clog2(BITS_A) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BITS_A - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FINISH
    } state_t;

    state_t            state;
    logic [BITS_A-1:0] dividend;
    logic [BITS_B-1:0] divisor;
    // Partial remainder is always < divisor after a step, so BITS_B bits hold
    // it; only the shifted value R' needs the extra top bit.
    logic [BITS_B-1:0] part_rem;
    logic [IW-1:0]     idx;

    logic [BITS_B:0]   shifted;
    logic [BITS_B-1:0] diff;
    logic              fits;
    logic [IW-1:0]     start_idx;
    logic [BITS_A-1:0] start_quo;

`ifdef ACCUM_DIV_EARLY_EXIT_EN
    // Index of the most significant set bit, 0 for a zero dividend.
    function automatic logic [IW-1:0] msb_index(input logic [BITS_A-1:0] a);
        logic [IW-1:0] m;
        m = '0;
        for (int b = 0; b < BITS_A; b++) begin
            if (a[b]) m = IW'(b);
        end
        return m;
    endfunction

    // Quotient bits above the leading one are zero, except for a zero
    // divisor where every bit must come out as one.
    assign start_idx = msb_index(i_dat_a);
    assign start_quo = (i_dat_b == '0) ? '1 : '0;
`else
    assign start_idx = LAST_IDX;
    assign start_quo = '0;
`endif

    assign o_rem = part_rem;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The difference is only kept when it is below the divisor, so it is
    // exact modulo 2^BITS_B.
    always_comb begin
        shifted = {part_rem, dividend[idx]};
        fits    = (shifted >= {1'b0, divisor});
        diff    = shifted[BITS_B-1:0] - divisor;
    end

    // Control FSM and datapath; the quotient is built in place in o_quo.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            o_rdy    <= 1'b0;
            o_val    <= 1'b0;
            o_quo    <= '0;
            part_rem <= '0;
            idx      <= '0;
            dividend <= '0;
            divisor  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (o_rdy && i_val) begin
                        dividend <= i_dat_a;
                        divisor  <= i_dat_b;
                        part_rem <= '0;
                        idx      <= start_idx;
                        o_quo    <= start_quo;
                        o_rdy    <= 1'b0;
                        state    <= DIV;
                    end else begin
                        o_rdy <= 1'b1;
                    end
                end
                DIV: begin
                    o_quo[idx] <= fits;
                    part_rem   <= fits ? diff : shifted[BITS_B-1:0];
                    if (idx == '0) begin
                        o_val <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                FINISH: begin
                    if (i_rdy) begin
                        o_val <= 1'b0;
                        o_rdy <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
